// File: rtl/fixpt_pkg.sv
// Shared fixed-point helpers for the speech datapath: saturation limits,
// rounding constant, 32-bit saturating add and high-half extraction.
package fixpt_pkg;

    localparam logic [31:0] MAX_32  = 32'h7FFF_FFFF;
    localparam logic [31:0] MIN_32  = 32'h8000_0000;
    localparam logic [15:0] MAX_16  = 16'h7FFF;
    localparam logic [15:0] MIN_16  = 16'h8000;
    localparam logic [31:0] ROUND_K = 32'h0000_8000;

    typedef struct packed {
        logic [31:0] sum;
        logic        ovf;
    } sat32_t;

    // L_add: two's-complement add clamped to the 32-bit range.
    // Overflow only when both operands share a sign and the result does not.
    function automatic sat32_t sat_add32(input logic [31:0] a, input logic [31:0] b);
        sat32_t r;
        logic [31:0] s;
        s     = a + b;
        r.ovf = (a[31] == b[31]) && (s[31] != a[31]);
        if (r.ovf) begin
            r.sum = a[31] ? MIN_32 : MAX_32;
        end else begin
            r.sum = s;
        end
        return r;
    endfunction

    // extract_h: upper Q15 half of a Q31 value.
    function automatic logic [15:0] extract_h(input logic [31:0] a);
        return a[31:16];
    endfunction

endpackage

// File: rtl/l_mult_q15.sv
// L_mult: Q15 x Q15 -> Q31 doubling multiply. The only overflowing input
// pair, -1.0 * -1.0, clamps to MAX_32 and raises ovf_o.
module l_mult_q15
    import fixpt_pkg::*;
(
    input  logic [15:0] x_i,
    input  logic [15:0] y_i,
    output logic [31:0] p_o,
    output logic        ovf_o
);

    logic signed [31:0] prod;

    // Signed product, doubled, with the single saturating corner case.
    always_comb begin
        prod  = $signed(x_i) * $signed(y_i);
        ovf_o = (x_i == MIN_16) && (y_i == MIN_16);
        if (ovf_o) begin
            p_o = MAX_32;
        end else begin
            p_o = {prod[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/l_mac_accum.sv
// Streaming Q15 multiply-accumulate: stage 1 registers L_mult of the sample
// pair, stage 2 L_adds it into a saturating 32-bit accumulator and, on the
// frame's last sample, registers the frame sum, its rounded high half, the
// sample count and the sticky overflow flag.
module l_mac_accum
    import fixpt_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic [15:0]      x,
    input  logic [15:0]      y,
    input  logic [31:0]      acc_init,
    output logic             out_valid,
    output logic [31:0]      out_acc,
    output logic [15:0]      out_hi,
    output logic [CNT_W-1:0] out_count,
    output logic             overflow,
    output logic             busy
);

    // Stage-1 product
    logic [31:0]      mult_p;
    logic             mult_ovf;
    logic             first_smp;

    // Stage-1 registers
    logic             open_q;
    logic             v1_q;
    logic             last1_q;
    logic             first1_q;
    logic             movf1_q;
    logic [31:0]      p1_q;
    logic [31:0]      init1_q;

    // Stage-2 running frame state
    logic [31:0]      acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             fovf_q;

    // Stage-2 next-state values
    logic [31:0]      base_d;
    sat32_t           sum_d;
    sat32_t           rnd_d;
    logic [CNT_W-1:0] cnt_base_d;
    logic [CNT_W-1:0] cnt_d;
    logic             fovf_d;

    // Output registers
    logic             out_valid_q;
    logic [31:0]      out_acc_q;
    logic [15:0]      out_hi_q;
    logic [CNT_W-1:0] out_count_q;
    logic             overflow_q;

    l_mult_q15 u_mult (
        .x_i   (x),
        .y_i   (y),
        .p_o   (mult_p),
        .ovf_o (mult_ovf)
    );

    assign first_smp = in_valid && !open_q;

    // Stage 1: capture product, frame markers and (on frame open) acc_init.
    // acc_init travels with the first sample so back-to-back frames cannot
    // see each other's starting value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            open_q   <= 1'b0;
            v1_q     <= 1'b0;
            last1_q  <= 1'b0;
            first1_q <= 1'b0;
            movf1_q  <= 1'b0;
            p1_q     <= '0;
            init1_q  <= '0;
        end else begin
            v1_q <= in_valid;
            if (in_valid) begin
                open_q   <= !in_last;
                last1_q  <= in_last;
                first1_q <= first_smp;
                movf1_q  <= mult_ovf;
                p1_q     <= mult_p;
                if (first_smp) begin
                    init1_q <= acc_init;
                end
            end
        end
    end

    // Stage 2 combinational: saturating accumulate, count and overflow update,
    // plus the rounding add used only when the frame closes.
    always_comb begin
        base_d     = first1_q ? init1_q : acc_q;
        sum_d      = sat_add32(base_d, p1_q);
        cnt_base_d = first1_q ? '0 : cnt_q;
        cnt_d      = (cnt_base_d == '1) ? cnt_base_d : cnt_base_d + CNT_W'(1);
        fovf_d     = (first1_q ? 1'b0 : fovf_q) | movf1_q | sum_d.ovf;
        rnd_d      = sat_add32(sum_d.sum, ROUND_K);
    end

    // Stage 2 registers: running state per sample, outputs on frame close.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            fovf_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            out_hi_q    <= '0;
            out_count_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (v1_q) begin
                acc_q  <= sum_d.sum;
                cnt_q  <= cnt_d;
                fovf_q <= fovf_d;
                if (last1_q) begin
                    out_valid_q <= 1'b1;
                    out_acc_q   <= sum_d.sum;
                    out_hi_q    <= extract_h(rnd_d.sum);
                    out_count_q <= cnt_d;
                    overflow_q  <= fovf_d | rnd_d.ovf;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_acc   = out_acc_q;
    assign out_hi    = out_hi_q;
    assign out_count = out_count_q;
    assign overflow  = overflow_q;
    assign busy      = open_q | v1_q;

endmodule

// File: tb/tb_l_mac_accum.sv
// Directed bench for l_mac_accum: table of frames with hand-computed
// results, plus sequences for gaps, back-to-back frames, count saturation
// and mid-frame reset.
module tb_l_mac_accum;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_last;
    logic [15:0] x;
    logic [15:0] y;
    logic [31:0] acc_init;
    logic        out_valid;
    logic [31:0] out_acc;
    logic [15:0] out_hi;
    logic [7:0]  out_count;
    logic        overflow;
    logic        busy;

    int total;
    int bad;
    int vcnt;

    l_mac_accum #(.CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .x         (x),
        .y         (y),
        .acc_init  (acc_init),
        .out_valid (out_valid),
        .out_acc   (out_acc),
        .out_hi    (out_hi),
        .out_count (out_count),
        .overflow  (overflow),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (out_valid === 1'b1) vcnt++;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct packed {
        logic [31:0]       init;
        logic [1:0]        n;
        logic [2:0][15:0]  xs;
        logic [2:0][15:0]  ys;
        logic [31:0]       acc;
        logic [15:0]       hi;
        logic [7:0]        cnt;
        logic              ovf;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic l, input logic [15:0] xx,
                        input logic [15:0] yy, input logic [31:0] ii);
        @(posedge clk);
        #1;
        in_valid = v;
        in_last  = l;
        x        = xx;
        y        = yy;
        acc_init = ii;
    endtask

    // Called right after the last sample was driven: result must appear
    // exactly two edges later, for one cycle, and then hold.
    task automatic check_frame(input string nm, input logic [31:0] eacc,
                               input logic [15:0] ehi, input logic [7:0] ecnt,
                               input logic eovf);
        step(1'b0, 1'b0, 16'h0, 16'h0, 32'h0);
        chk({nm, ".early"}, {31'b0, out_valid}, 32'd0);
        chk({nm, ".busy1"}, {31'b0, busy}, 32'd1);
        @(posedge clk);
        #1;
        chk({nm, ".valid"}, {31'b0, out_valid}, 32'd1);
        chk({nm, ".acc"}, out_acc, eacc);
        chk({nm, ".hi"}, {16'b0, out_hi}, {16'b0, ehi});
        chk({nm, ".cnt"}, {24'b0, out_count}, {24'b0, ecnt});
        chk({nm, ".ovf"}, {31'b0, overflow}, {31'b0, eovf});
        chk({nm, ".busy0"}, {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1;
        chk({nm, ".pulse"}, {31'b0, out_valid}, 32'd0);
        chk({nm, ".hold"}, out_acc, eacc);
    endtask

    initial begin
        int v0;
        total    = 0;
        bad      = 0;
        vcnt     = 0;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        x        = '0;
        y        = '0;
        acc_init = '0;

        //                init         n     xs[2..0]                        ys[2..0]                        acc           hi        cnt   ovf
        tbl[0] = '{32'h0,        2'd2, {16'h0, 16'h4000, 16'h4000}, {16'h0, 16'h4000, 16'h4000}, 32'h4000_0000, 16'h4000, 8'd2, 1'b0};
        tbl[1] = '{32'h0,        2'd1, {16'h0, 16'h0, 16'h8000},    {16'h0, 16'h0, 16'h8000},    32'h7FFF_FFFF, 16'h7FFF, 8'd1, 1'b1};
        tbl[2] = '{32'h0,        2'd3, {16'h8000, 16'h7FFF, 16'h7FFF}, {16'h7FFF, 16'h7FFF, 16'h7FFF}, 32'h0000_FFFF, 16'h0001, 8'd3, 1'b1};
        tbl[3] = '{32'h8000_0000, 2'd1, {16'h0, 16'h0, 16'h8000},   {16'h0, 16'h0, 16'h7FFF},    32'h8000_0000, 16'h8000, 8'd1, 1'b1};
        tbl[4] = '{32'h1234_5678, 2'd1, {16'h0, 16'h0, 16'hC000},   {16'h0, 16'h0, 16'h4000},    32'hF234_5678, 16'hF234, 8'd1, 1'b0};
        tbl[5] = '{32'h0,        2'd2, {16'h0, 16'hFFFF, 16'h8000}, {16'h0, 16'h0001, 16'h8000}, 32'h7FFF_FFFD, 16'h7FFF, 8'd2, 1'b1};

        #1;
        chk("rst.valid", {31'b0, out_valid}, 32'd0);
        chk("rst.acc", out_acc, 32'd0);
        chk("rst.hi", {16'b0, out_hi}, 32'd0);
        chk("rst.cnt", {24'b0, out_count}, 32'd0);
        chk("rst.ovf", {31'b0, overflow}, 32'd0);
        chk("rst.busy", {31'b0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            for (int unsigned k = 0; k < tbl[i].n; k++) begin
                step(1'b1, k == tbl[i].n - 1, tbl[i].xs[k], tbl[i].ys[k],
                     (k == 0) ? tbl[i].init : 32'hDEAD_BEEF);
            end
            check_frame($sformatf("tbl%0d", i), tbl[i].acc, tbl[i].hi, tbl[i].cnt, tbl[i].ovf);
        end

        // Gaps inside a frame, with a stray in_last while in_valid is low.
        step(1'b1, 1'b0, 16'h4000, 16'h4000, 32'h0000_0100);
        step(1'b0, 1'b1, 16'h7FFF, 16'h7FFF, 32'h0);
        step(1'b0, 1'b1, 16'h7FFF, 16'h7FFF, 32'h0);
        chk("gap.busy", {31'b0, busy}, 32'd1);
        chk("gap.novalid", {31'b0, out_valid}, 32'd0);
        step(1'b1, 1'b1, 16'h4000, 16'h4000, 32'hDEAD_BEEF);
        check_frame("gap", 32'h4000_0100, 16'h4000, 8'd2, 1'b0);

        // Back-to-back single-sample frames on consecutive cycles.
        step(1'b1, 1'b1, 16'h0, 16'h0, 32'h0000_8000);
        step(1'b1, 1'b1, 16'h0, 16'h0, 32'h0000_0000);
        step(1'b0, 1'b0, 16'h0, 16'h0, 32'h0);
        chk("b2b.v1", {31'b0, out_valid}, 32'd1);
        chk("b2b.acc1", out_acc, 32'h0000_8000);
        chk("b2b.hi1", {16'b0, out_hi}, 32'h0001);
        chk("b2b.cnt1", {24'b0, out_count}, 32'd1);
        @(posedge clk);
        #1;
        chk("b2b.v2", {31'b0, out_valid}, 32'd1);
        chk("b2b.acc2", out_acc, 32'h0);
        chk("b2b.hi2", {16'b0, out_hi}, 32'h0);
        chk("b2b.ovf2", {31'b0, overflow}, 32'd0);
        chk("b2b.cnt2", {24'b0, out_count}, 32'd1);
        @(posedge clk);
        #1;
        chk("b2b.end", {31'b0, out_valid}, 32'd0);

        // Sample counter saturates at 255.
        for (int k = 0; k < 300; k++) begin
            step(1'b1, k == 299, 16'h0, 16'h0, 32'h0);
        end
        check_frame("cntsat", 32'h0, 16'h0, 8'd255, 1'b0);

        // Leave non-zero outputs before the reset test.
        step(1'b1, 1'b1, 16'h4000, 16'h4000, 32'h0);
        check_frame("pre", 32'h2000_0000, 16'h2000, 8'd1, 1'b0);

        // Reset after 3 of 5 samples: partial frame discarded.
        v0 = vcnt;
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 16'h1000, 16'h1000, 32'h0000_1234);
        end
        #2;
        reset = 1'b1;
        #1;
        in_valid = 1'b0;
        chk("mrst.valid", {31'b0, out_valid}, 32'd0);
        chk("mrst.acc", out_acc, 32'd0);
        chk("mrst.hi", {16'b0, out_hi}, 32'd0);
        chk("mrst.cnt", {24'b0, out_count}, 32'd0);
        chk("mrst.ovf", {31'b0, overflow}, 32'd0);
        chk("mrst.busy", {31'b0, busy}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 1'b1, 16'h0100, 16'h0100, 32'h0);
        check_frame("postrst", 32'h0002_0000, 16'h0002, 8'd1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("mrst.pulses", vcnt - v0, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/l_mac_accum.md
Name: l_mac_accum

Overview:
- Streaming fixed-point multiply-accumulate stage, bit-exact to the ITU-T basic ops: L_mult of two Q15 operands, then L_add into a 32-bit saturating accumulator.
- Sits directly upstream of the 32-bit saturating adder and round/extract stages in the speech datapath.
- Consumes a frame of sample pairs and emits one saturated 32-bit sum, its rounded Q15 high half, a sample count and a sticky overflow flag per frame.

Parameters:
CNT_W, 8, width of per-frame sample counter (count saturates at 2^CNT_W-1)

Ports:
clk        input   1      clock, rising edge
reset      input   1      asynchronous, active-high reset
in_valid   input   1      sample pair valid this cycle; no backpressure, always accepted
in_last    input   1      qualifies final sample of frame (sampled only when in_valid=1)
x          input   16     signed Q15 operand
y          input   16     signed Q15 operand
acc_init   input   32     signed starting accumulator, sampled with first sample of frame
out_valid  output  1      one-cycle pulse: frame result valid
out_acc    output  32     signed saturated frame sum
out_hi     output  16     round(out_acc) = extract_h(L_add(out_acc, 0x00008000))
out_count  output  CNT_W  samples in frame
overflow   output  1      any saturation occurred in frame (multiply, accumulate or round)
busy       output  1      frame open or pipeline holds unretired sample

Behaviour:
- Reset values: out_valid=0, out_acc=0, out_hi=0, out_count=0, overflow=0, busy=0. All internal regs and the first-of-frame flag return to "next sample opens a frame".
- Stage 1, registered on accepted sample:
  - p1 = L_mult(x,y) = (x*y)<<1.
  - x=y=0x8000 gives p1=0x7FFFFFFF, mult_ovf1=1.
  - Carries v1, last1, first1, mult_ovf1.
- Stage 2, when v1=1:
  - base = first1 ? acc_init_latched : acc.
  - acc <= sat32(base + p1).
  - Saturation rule: equal operand signs and result sign differs from base clamp to 0x7FFFFFFF if base>=0, else 0x80000000.
  - Saturation is per-add, not sticky-clamp; later adds proceed from the clamped value.
- acc_init is latched in the cycle the first sample of a frame is accepted.
- A frame opens on the first accepted sample after reset or after an accepted in_last.
- Frame state:
  - Count increments per stage-2 sample, saturating at max.
  - Overflow accumulator ORs mult_ovf and add saturation.
- Frame close: when stage 2 processes last1=1, on the same edge:
  - out_acc, out_count and out_hi (round, with its own saturation folded into overflow) register.
  - out_valid=1 for exactly one cycle.
- Latency: sample with in_last accepted at edge t gives out_valid high after edge t+2.
- Outputs hold their values until the next frame close.
- Single-sample frame (first and last together): result = sat32(acc_init + p1), out_count=1.
- Gaps (in_valid=0) inside a frame are allowed; state is held.
- Back-to-back frames are supported: the last sample of frame N and the first of frame N+1 may occupy consecutive cycles. The first sample uses acc_init, not the running acc.
- busy = frame open OR v1.
- in_last with in_valid=0 is ignored.
- Reset mid-frame discards the partial frame; no out_valid is produced.

Decomposition:
- Shared package fixpt_pkg holds:
  - Constants MAX_32=0x7FFFFFFF, MIN_32=0x80000000, MAX_16=0x7FFF, MIN_16=0x8000, ROUND_K=0x00008000.
  - Functions sat_add32 (returns sum and ovf) and extract_h.
- One natural sub-module, l_mult_q15: combinational 16x16 doubling multiply with its 0x8000*0x8000 saturation and ovf output. It is reused by later mac/msu stages.

Test Plan:
- Two-sample frame, acc_init=0, (0x4000,0x4000) twice with last on 2nd → out_acc=0x40000000, out_hi=0x4000, out_count=2, overflow=0, out_valid two cycles after last.
- Single sample (0x8000,0x8000), acc_init=0 → out_acc=0x7FFFFFFF, overflow=1, out_hi=0x7FFF (round saturates).
- Accumulate saturation then recovery: (0x7FFF,0x7FFF)×2 then (0x8000,0x7FFF) → clamped 0x7FFFFFFF, then 0x7FFFFFFF+0x80010000 gives out_acc=0x0000FFFF, out_hi=0x0001, overflow=1.
- Negative clamp: acc_init=0x80000000 plus (0x8000,0x7FFF) → out_acc=0x80000000, overflow=1.
- Back-to-back frames with acc_init 0x00008000 then 0x00000000, one sample (0,0) each, consecutive cycles → out_hi=0x0001 then 0x0000, second frame overflow=0, two consecutive out_valid pulses.
- Reset asserted after 3 of 5 samples, then new 1-sample frame (0x0100,0x0100), acc_init=0 → only one out_valid, out_acc=0x00020000, out_count=1; all outputs 0 during reset.
